// File: rtl/life_display_pipe.sv
// life_display_pipe: 3-stage scan-coordinate to cell-colour renderer for the Life board.
// Optional grid lines between cells are enabled by defining LIFE_GRID_LINE_EN.
`ifndef MODE_EDIT
`define MODE_EDIT 1'b1
`endif

module life_display_pipe #(
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned SCAN_W       = 10,
   parameter int unsigned PX_BOUND_LM  = 50,
   parameter int unsigned PX_BOUND_RM  = 400,
   parameter int unsigned PX_BOUND_UM  = 50,
   parameter int unsigned PX_BOUND_DM  = 400,
   parameter int unsigned MIN_SHIFT    = 3,
   parameter int unsigned MAX_SHIFT    = 7,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              mode,
   input  logic [SCAN_W-1:0] scan_x,
   input  logic [SCAN_W-1:0] scan_y,
   input  logic [ADDR_W-1:0] win_x,
   input  logic [ADDR_W-1:0] win_y,
   input  logic [7:0]        visi_cell_num,
   input  logic [ADDR_W-1:0] cur_x,
   input  logic [ADDR_W-1:0] cur_y,
   output logic [ADDR_W-1:0] cell_x,
   output logic [ADDR_W-1:0] cell_y,
   output logic              cell_rd_en,
   input  logic              cell_state,
   output logic              in_disp_area,
   output logic [11:0]       disp_value_RGB
);

   localparam int unsigned SHIFT_W = $clog2(MAX_SHIFT + 1);
   localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [SHIFT_W-1:0] shift_c, shift_sh, shift_s1;
   logic [ADDR_W-1:0]  win_x_sh, win_y_sh, win_x_s1, win_y_s1;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_on;
   logic               in_area_s1;
   logic [SCAN_W-1:0]  off_x_s1, off_y_s1;
   logic [ADDR_W-1:0]  cell_x_c, cell_y_c;
   logic               cursor_hit_c, cursor_hit_s2;
   logic [11:0]        rgb_c;

   // Zoom: the msb of the requested cell count picks the cell width, clamped to the legal range.
   always_comb begin
      shift_c = SHIFT_W'(MAX_SHIFT);
      for (int i = 0; i < 8; i++) begin
         if (visi_cell_num[i]) begin
            if (i >= int'(MAX_SHIFT - MIN_SHIFT)) shift_c = SHIFT_W'(MIN_SHIFT);
            else                                  shift_c = SHIFT_W'(int'(MAX_SHIFT) - i);
         end
      end
   end

   // Frame-synchronous shadow of window/zoom, plus the cursor blink timer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         win_x_sh  <= '0;
         win_y_sh  <= '0;
         shift_sh  <= SHIFT_W'(MAX_SHIFT);
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else begin
         if (frame_start) begin
            win_x_sh <= win_x;
            win_y_sh <= win_y;
            shift_sh <= shift_c;
         end
         if (mode != `MODE_EDIT) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
         end else if (frame_start) begin
            if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
               blink_cnt <= '0;
               blink_on  <= ~blink_on;
            end else begin
               blink_cnt <= blink_cnt + BLINK_W'(1);
            end
         end
      end
   end

   // Stage 1: area test and offsets; each pixel carries its own copy of the shadow set.
   always_ff @(posedge clk) begin
      if (!rst) begin
         in_area_s1 <= 1'b0;
         off_x_s1   <= '0;
         off_y_s1   <= '0;
         shift_s1   <= '0;
         win_x_s1   <= '0;
         win_y_s1   <= '0;
      end else begin
         in_area_s1 <= (scan_x > SCAN_W'(PX_BOUND_LM)) && (scan_x < SCAN_W'(PX_BOUND_RM)) &&
                       (scan_y > SCAN_W'(PX_BOUND_UM)) && (scan_y < SCAN_W'(PX_BOUND_DM));
         off_x_s1   <= scan_x - SCAN_W'(PX_BOUND_LM);
         off_y_s1   <= scan_y - SCAN_W'(PX_BOUND_UM);
         shift_s1   <= shift_sh;
         win_x_s1   <= win_x_sh;
         win_y_s1   <= win_y_sh;
      end
   end

   always_comb begin
      cell_x_c     = win_x_s1 + ADDR_W'(off_x_s1 >> shift_s1);
      cell_y_c     = win_y_s1 + ADDR_W'(off_y_s1 >> shift_s1);
      cursor_hit_c = (mode == `MODE_EDIT) && blink_on && (cell_x_c == cur_x) && (cell_y_c == cur_y);
   end

   // Stage 2: cell address and read request to the RAM.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cell_x        <= '0;
         cell_y        <= '0;
         cell_rd_en    <= 1'b0;
         cursor_hit_s2 <= 1'b0;
      end else begin
         cell_x        <= cell_x_c;
         cell_y        <= cell_y_c;
         cell_rd_en    <= in_area_s1;
         cursor_hit_s2 <= cursor_hit_c;
      end
   end

`ifdef LIFE_GRID_LINE_EN
   logic [SCAN_W-1:0] mask_c;
   logic              edge_x_s2, edge_y_s2;

   // First pixel row/column of each cell marks the grid line.
   always_comb mask_c = (SCAN_W'(1) << shift_s1) - SCAN_W'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         edge_x_s2 <= 1'b0;
         edge_y_s2 <= 1'b0;
      end else begin
         edge_x_s2 <= (off_x_s1 & mask_c) == '0;
         edge_y_s2 <= (off_y_s1 & mask_c) == '0;
      end
   end
`endif

   // Stage 3 colour select, in priority order.
   always_comb begin
      rgb_c = 12'hFFF;
      if (!cell_rd_en)          rgb_c = 12'h000;
      else if (cursor_hit_s2)   rgb_c = 12'h0F0;
`ifdef LIFE_GRID_LINE_EN
      else if (edge_x_s2 || edge_y_s2) rgb_c = 12'h000;
`endif
      else if (cell_state)      rgb_c = 12'h00F;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         disp_value_RGB <= 12'h000;
         in_disp_area   <= 1'b0;
      end else begin
         disp_value_RGB <= rgb_c;
         in_disp_area   <= cell_rd_en;
      end
   end

endmodule

// File: tb/tb_life_display_pipe.sv
// Directed bench for life_display_pipe: latency, zoom latch, wrap, grid, cursor blink, bounds, reset.
`ifndef MODE_EDIT
`define MODE_EDIT 1'b1
`endif

module tb_life_display_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_start;
   logic        mode;
   logic [9:0]  scan_x, scan_y;
   logic [7:0]  win_x, win_y, visi_cell_num, cur_x, cur_y;
   logic [7:0]  cell_x, cell_y;
   logic        cell_rd_en, cell_state, in_disp_area;
   logic [11:0] disp_value_RGB;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef LIFE_GRID_LINE_EN
   localparam bit GRID_ON = 1'b1;
`else
   localparam bit GRID_ON = 1'b0;
`endif
   // Colour of an empty cell pixel that lies on a cell's first row/column.
   localparam logic [11:0] EDGE_EMPTY = GRID_ON ? 12'h000 : 12'hFFF;
   localparam logic [11:0] EDGE_LIVE  = GRID_ON ? 12'h000 : 12'h00F;

   life_display_pipe #(.BLINK_FRAMES(2)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .mode(mode),
      .scan_x(scan_x), .scan_y(scan_y), .win_x(win_x), .win_y(win_y),
      .visi_cell_num(visi_cell_num), .cur_x(cur_x), .cur_y(cur_y),
      .cell_x(cell_x), .cell_y(cell_y), .cell_rd_en(cell_rd_en),
      .cell_state(cell_state), .in_disp_area(in_disp_area),
      .disp_value_RGB(disp_value_RGB)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_pulse();
      scan_x = '0; scan_y = '0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // Present one pixel for a single cycle, then out-of-area filler, checking exact latency.
   task automatic pulse_pixel(input string tag, input int x, input int y, input logic exp_in,
                              input logic [7:0] ecx, input logic [7:0] ecy, input logic [11:0] ergb);
      scan_x = 10'(x); scan_y = 10'(y);
      tick();
      scan_x = '0; scan_y = '0;
      tick();
      chk({tag, "_rd_en"}, 32'(cell_rd_en), 32'(exp_in));
      if (exp_in) begin
         chk({tag, "_cell_x"}, 32'(cell_x), 32'(ecx));
         chk({tag, "_cell_y"}, 32'(cell_y), 32'(ecy));
      end
      tick();
      chk({tag, "_rgb"}, 32'(disp_value_RGB), 32'(ergb));
      chk({tag, "_in_area"}, 32'(in_disp_area), 32'(exp_in));
   endtask

   initial begin
      rst = 1'b0; frame_start = 1'b0; mode = 1'b0; cell_state = 1'b0;
      scan_x = '0; scan_y = '0; win_x = '0; win_y = '0;
      visi_cell_num = 8'd16; cur_x = '0; cur_y = '0;
      tick(); tick();
      chk("reset_rgb", 32'(disp_value_RGB), 32'h000);
      chk("reset_in_area", 32'(in_disp_area), 32'h0);
      chk("reset_rd_en", 32'(cell_rd_en), 32'h0);
      chk("reset_cell_x", 32'(cell_x), 32'h0);
      rst = 1'b1;

      // Basic mapping with 8 px cells; run mode so the cursor at (0,0) is not drawn.
      frame_pulse();
      pulse_pixel("basic", 51, 51, 1'b1, 8'h00, 8'h00, 12'hFFF);
      cell_state = 1'b1;
      pulse_pixel("grid", 58, 60, 1'b1, 8'h01, 8'h01, EDGE_LIVE);
      pulse_pixel("live", 60, 61, 1'b1, 8'h01, 8'h01, 12'h00F);
      cell_state = 1'b0;

      // Toroidal wrap of the column address.
      win_x = 8'hFE;
      frame_pulse();
      pulse_pixel("wrap", 74, 51, 1'b1, 8'h01, 8'h00, EDGE_EMPTY);
      win_x = 8'h00;
      frame_pulse();

      // Zoom change mid-frame holds until frame_start; the frame_start pixel uses the old zoom.
      visi_cell_num = 8'd2;
      pulse_pixel("zoom_hold", 114, 51, 1'b1, 8'h08, 8'h00, EDGE_EMPTY);
      scan_x = 10'd114; scan_y = 10'd51; frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      scan_x = '0; scan_y = '0;
      chk("zoom_fs_pixel_cell_x", 32'(cell_x), 32'h08);
      tick();
      chk("zoom_new_cell_x", 32'(cell_x), 32'h01);
      tick();
      visi_cell_num = 8'd16;
      frame_pulse();

      // Cursor blink with a 2-frame half period.
      mode = `MODE_EDIT;
      pulse_pixel("cur_on", 51, 51, 1'b1, 8'h00, 8'h00, 12'h0F0);
      pulse_pixel("cur_miss", 60, 51, 1'b1, 8'h01, 8'h00, 12'hFFF);
      frame_pulse();
      pulse_pixel("cur_on_1frame", 51, 51, 1'b1, 8'h00, 8'h00, 12'h0F0);
      frame_pulse();
      pulse_pixel("cur_off", 51, 51, 1'b1, 8'h00, 8'h00, 12'hFFF);
      frame_pulse();
      pulse_pixel("cur_off_1frame", 51, 51, 1'b1, 8'h00, 8'h00, 12'hFFF);
      frame_pulse();
      pulse_pixel("cur_back", 51, 51, 1'b1, 8'h00, 8'h00, 12'h0F0);
      frame_pulse(); frame_pulse();
      mode = 1'b0;
      pulse_pixel("run_mode", 51, 51, 1'b1, 8'h00, 8'h00, 12'hFFF);
      frame_pulse(); frame_pulse();
      pulse_pixel("run_mode_2", 51, 51, 1'b1, 8'h00, 8'h00, 12'hFFF);
      mode = `MODE_EDIT;
      pulse_pixel("edit_reentry", 51, 51, 1'b1, 8'h00, 8'h00, 12'h0F0);
      mode = 1'b0;

      // Strict bounds on all four sides, plus the last in-area pixel.
      pulse_pixel("bound_lm", 50, 200, 1'b0, 8'h00, 8'h00, 12'h000);
      pulse_pixel("bound_rm", 400, 200, 1'b0, 8'h00, 8'h00, 12'h000);
      pulse_pixel("bound_um", 200, 50, 1'b0, 8'h00, 8'h00, 12'h000);
      pulse_pixel("bound_dm", 200, 400, 1'b0, 8'h00, 8'h00, 12'h000);
      pulse_pixel("corner_in", 399, 399, 1'b1, 8'h2B, 8'h2B, 12'hFFF);

      // Reset mid-stream flushes the pipeline; shadow zoom returns to the widest cells.
      scan_x = 10'd100; scan_y = 10'd100;
      tick(); tick(); tick();
      chk("pre_reset_rgb", 32'(disp_value_RGB), 32'hFFF);
      chk("pre_reset_cell_x", 32'(cell_x), 32'h06);
      rst = 1'b0;
      tick();
      chk("mid_reset_rgb", 32'(disp_value_RGB), 32'h000);
      chk("mid_reset_in_area", 32'(in_disp_area), 32'h0);
      chk("mid_reset_rd_en", 32'(cell_rd_en), 32'h0);
      chk("mid_reset_cell_x", 32'(cell_x), 32'h00);
      rst = 1'b1;
      tick();
      chk("flush1_rgb", 32'(disp_value_RGB), 32'h000);
      tick();
      chk("flush2_rgb", 32'(disp_value_RGB), 32'h000);
      chk("flush2_cell_x", 32'(cell_x), 32'h00);
      chk("flush2_rd_en", 32'(cell_rd_en), 32'h1);
      tick();
      chk("flush3_rgb", 32'(disp_value_RGB), 32'hFFF);
      chk("flush3_in_area", 32'(in_disp_area), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/life_display_pipe.md
Name: life_display_pipe

Overview:
- Pipelined pixel-to-cell renderer for the Life board; successor to the combinational display controller.
- Maps VGA scan coordinates to toroidal cell addresses.
- Issues a read to the synchronous cell RAM and produces a registered 12-bit RGB value for the VGA core.
- Adds frame-synchronous zoom/window latching, a blinking edit cursor, parametrised bounds and widths, and fixed 3-cycle latency.

Parameters:
- ADDR_W, 8, cell coordinate width; addresses wrap modulo 2^ADDR_W
- SCAN_W, 10, scan coordinate width
- PX_BOUND_LM, 50, left bound; pixel in area when scan_x > LM
- PX_BOUND_RM, 400, right bound; in area when scan_x < RM
- PX_BOUND_UM, 50, top bound; in area when scan_y > UM
- PX_BOUND_DM, 400, bottom bound; in area when scan_y < DM
- MIN_SHIFT, 3, smallest log2 cell width (8 px)
- MAX_SHIFT, 7, largest log2 cell width (128 px)
- BLINK_FRAMES, 30, frame_start pulses per cursor blink half-period

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- frame_start  in  1  one-cycle pulse at start of each frame
- mode  in  1  equals `MODE_EDIT for edit mode; anything else is run mode
- scan_x  in  SCAN_W  current scan column
- scan_y  in  SCAN_W  current scan row
- win_x  in  ADDR_W  window origin column
- win_y  in  ADDR_W  window origin row
- visi_cell_num  in  8  requested visible cells per side (zoom)
- cur_x  in  ADDR_W  cursor column
- cur_y  in  ADDR_W  cursor row
- cell_x  out  ADDR_W  cell RAM read column
- cell_y  out  ADDR_W  cell RAM read row
- cell_rd_en  out  1  cell RAM read enable
- cell_state  in  1  RAM read data; valid exactly 1 cycle after cell_x/cell_y
- in_disp_area  out  1  in-area flag aligned with disp_value_RGB
- disp_value_RGB  out  12  pixel colour to the VGA core

Behaviour:
- Reset (rst==0 at clk edge): all pipeline registers and outputs 0, disp_value_RGB=12'h000, shadow win_x/win_y=0, shadow shift=MAX_SHIFT, blink counter=0, blink_on=1.
- Shadow latching: on frame_start, win_x, win_y and shift are latched. shift = clamp(MAX_SHIFT - msb_index(visi_cell_num), MIN_SHIFT, MAX_SHIFT); visi_cell_num==0 gives MAX_SHIFT. Pixels presented on the cycle after frame_start and later use the new values. The pixel presented in the frame_start cycle uses the old values.
- Stage 1 (cycle N+1) registers:
  - in_area = all four strict bound compares
  - off_x = scan_x - PX_BOUND_LM and off_y = scan_y - PX_BOUND_UM, each SCAN_W bits
  - a copy of the shadow shift/win, so every pixel carries a consistent set
- Stage 2 (cycle N+2) registers:
  - cell_x = win_x + (off_x >> shift), truncated to ADDR_W (wraps); cell_y likewise
  - edge_x = (off_x & ((1<<shift)-1)) == 0; edge_y likewise
  - cell_rd_en = in_area
  - cursor_hit = (mode==`MODE_EDIT) & blink_on & cell_x==cur_x & cell_y==cur_y
- Stage 3 (cycle N+3) registers disp_value_RGB and in_disp_area. Colour priority:
  1. !in_area: 12'h000
  2. cursor_hit: 12'h0F0
  3. grid line (feature enabled, edge_x|edge_y): 12'h000
  4. cell_state: 12'h00F
  5. otherwise 12'hFFF
- Total latency scan to RGB: exactly 3 cycles, one pixel per cycle, no stalls.
- Blink:
  - The counter increments on frame_start only while mode==`MODE_EDIT.
  - At BLINK_FRAMES-1 with frame_start, the counter goes to 0 and blink_on toggles.
  - While mode is not `MODE_EDIT, counter=0 and blink_on=1, so the cursor shows immediately on entering edit mode.
- Out-of-area pixels still advance through the pipeline; cell_rd_en=0 for them. Their cell_x/cell_y values are don't-care but must be deterministic.
- Reset mid-line: pipeline flushes, and the next 3 outputs are the reset values.

Optional Feature:
- Macro: LIFE_GRID_LINE_EN.
- Defined: the first pixel row/column of each cell (edge_x|edge_y) is drawn 12'h000, except on the cursor cell, which is drawn solid.
- Undefined: no grid lines; edge logic is omitted and cells are drawn solid.

Test Plan:
- Reset, then frame_start with visi_cell_num=16, win=0; scan (51,51) -> 3 cycles later disp_value_RGB=12'hFFF (cell_state=0), in_disp_area=1; cell_x=0, cell_y=0 with cell_rd_en=1 at cycle 2.
- Grid: same setup with macro defined, scan (58,60) -> cell (1,1), edge_x=1 -> RGB 12'h000; with macro undefined -> colour from cell_state.
- Wrap: win_x=8'hFE, shift 3, scan_x=74 (off 24) -> cell_x=8'h01.
- Zoom latch: visi_cell_num changes 16->2 mid-frame -> shift stays 3 until frame_start, then becomes 6; scan_x=114 (off 64) -> cell_x=1.
- Cursor blink, BLINK_FRAMES=2, edit mode, cursor on cell (0,0) -> RGB 12'h0F0. After 2 frame_start pulses the cursor is not drawn; after 2 more it is drawn again. Switching to run mode -> cursor never drawn.
- Bounds and reset: scan_x=50 or 400 -> RGB 12'h000, in_disp_area=0, cell_rd_en=0; rst=0 mid-stream -> outputs 0 on the next edge.
